pc: RTL and testbench
=====================

# pc

Program-counter register for the RISC-V core's fetch stage. Holds the address of the instruction currently being fetched and loads the next-PC value selected upstream (sequential, branch or jump target) on each enabled clock edge. A write-enable input lets the hazard unit stall fetch. The block also supplies the sequential PC+4 and flags misaligned targets.

## Interface
- `XLEN`, default 32: PC width in bits; must be 32 or 64.
- `RESET_VECTOR`, default 0: value loaded into the PC on reset; must be 4-byte aligned.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: reset, synchronous and active-high.
- `pc_write`  input  1: load enable; 1 = load `next_pc`, 0 = hold (stall).
- `next_pc`  input  XLEN: candidate next address.
- `pc_out`  output  XLEN: current PC, registered.
- `pc_plus4`  output  XLEN: combinational `pc_out + 4`, modulo 2^XLEN.
- `misaligned_err`  output  1: registered one-cycle pulse on a rejected misaligned load.

## Operation
- Priority on each rising edge: `reset`, then `pc_write`, then hold.
- `reset`=1:
  - `pc_out` <= `RESET_VECTOR`.
  - `misaligned_err` <= 0.
  - `pc_write` and `next_pc` are ignored.
- `reset`=0, `pc_write`=1: `pc_out` loads `next_pc`, subject to the alignment rule in Configuration.
- `reset`=0, `pc_write`=0:
  - `pc_out` holds its value.
  - `misaligned_err` <= 0.
- `pc_plus4` always follows `pc_out` combinationally.
  - Wraps with no carry out: all-ones-minus-3 + 4 = 0.
- No internal state besides the PC register and the error flag. There is no FSM.
- `next_pc` is taken verbatim with no arithmetic on it. Any value, including a wrap to 0, is legal.

## Timing
- Load latency is 1 cycle: `next_pc` presented before edge N appears on `pc_out` after edge N.
- `pc_write` must be stable around the rising edge. No combinational path runs from `next_pc` to `pc_out`.
- Reset applied mid-run takes effect at the next edge and overrides a simultaneous `pc_write`=1.
- First edge with `reset`=0 and `pc_write`=1 loads `next_pc`. There is no extra dead cycle after reset release.
- Back-to-back loads are allowed every cycle.
- A stall of any length holds `pc_out` unchanged.
- `misaligned_err` is high for exactly the one cycle following the offending edge.

## Configuration
- Macro `PC_ALIGN_CHECK_EN`.
- Defined:
  - On a load edge where `next_pc[1:0]` != 0, the load is rejected.
  - `pc_out` holds its old value.
  - `misaligned_err` <= 1 for one cycle.
  - An aligned load clears `misaligned_err` to 0.
- Undefined:
  - `pc_out` loads `{next_pc[XLEN-1:2], 2'b00}`; the low bits are forced to zero.
  - `misaligned_err` is tied to 0.

## Test plan
- Reset: `reset`=1 for one edge with `next_pc`=0x40 and `pc_write`=1 -> `pc_out`=0x0, `pc_plus4`=0x4.
- Sequential run:
  - Stimulus: release reset, `pc_write`=1, `next_pc` = 4, 8, 12, 16, 20 on successive edges.
  - Response: `pc_out` = 4, 8, 12, 16, 20, each one cycle after it is presented.
- Stall: `pc_out`=8, `pc_write`=0 for 3 edges with `next_pc`=0x100 -> `pc_out` stays 8; next edge with `pc_write`=1 -> 0x100.
- Reset mid-run: `pc_out`=0x20, `reset`=1 with `pc_write`=1 and `next_pc`=0x30 -> `pc_out`=0x0.
- Wrap: `next_pc`=0xFFFFFFFC loaded -> `pc_plus4`=0x0; then load 0x0 -> `pc_out`=0x0.
- Misaligned, `next_pc`=0x13 loaded while `pc_out`=0x10:
  - With `PC_ALIGN_CHECK_EN`: `pc_out` stays 0x10 and `misaligned_err` pulses for one cycle.
  - Without it: `pc_out`=0x10 and `misaligned_err`=0.

Source files
------------

// File: rtl/pc.sv
// Fetch-stage program counter with sequential PC+4 and misaligned-load flag.
// Optional macro PC_ALIGN_CHECK_EN: reject misaligned loads and pulse misaligned_err.
module pc #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned_err
);

    logic [XLEN-1:0] pc_reg;

    assign pc_out   = pc_reg;
    assign pc_plus4 = pc_reg + XLEN'(4);

`ifdef PC_ALIGN_CHECK_EN

    logic err_reg;
    logic low_bits_set;

    assign low_bits_set   = |next_pc[1:0];
    assign misaligned_err = err_reg;

    // A misaligned target leaves the PC where it was so fetch does not wander off.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg  <= RESET_VECTOR;
            err_reg <= 1'b0;
        end else if (pc_write) begin
            if (low_bits_set) begin
                err_reg <= 1'b1;
            end else begin
                pc_reg  <= next_pc;
                err_reg <= 1'b0;
            end
        end else begin
            err_reg <= 1'b0;
        end
    end

`else

    logic unused_low_bits;

    // Low bits are dropped, so the target is rounded down to a word boundary.
    assign unused_low_bits = ^next_pc[1:0];
    assign misaligned_err  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_VECTOR;
        end else if (pc_write) begin
            pc_reg <= {next_pc[XLEN-1:2], 2'b00};
        end
    end

`endif

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: stimulus pushes expected state, a monitor pops and checks after each edge.
module tb_pc;

    localparam int XLEN = 32;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            pc_write;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned_err;

    pc #(.XLEN(XLEN), .RESET_VECTOR(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_write       (pc_write),
        .next_pc        (next_pc),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .misaligned_err (misaligned_err)
    );

    typedef struct {
        string           name;
        logic [XLEN-1:0] exp_pc;
        logic [XLEN-1:0] exp_p4;
        logic            exp_err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge; the expected state is what follows the next rising edge.
    task automatic step(input string name, input logic rst, input logic we, input logic [XLEN-1:0] npc,
                        input logic [XLEN-1:0] e_pc, input logic [XLEN-1:0] e_p4, input logic e_err);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        pc_write = we;
        next_pc  = npc;
        e.name    = name;
        e.exp_pc  = e_pc;
        e.exp_p4  = e_p4;
        e.exp_err = e_err;
        exp_q.push_back(e);
    endtask

    // Monitor: state is valid 1 time unit after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pc_out !== e.exp_pc) begin
                    errors++;
                    $display("FAIL %s pc_out: got %h expected %h", e.name, pc_out, e.exp_pc);
                end
                checks++;
                if (pc_plus4 !== e.exp_p4) begin
                    errors++;
                    $display("FAIL %s pc_plus4: got %h expected %h", e.name, pc_plus4, e.exp_p4);
                end
                checks++;
                if (misaligned_err !== e.exp_err) begin
                    errors++;
                    $display("FAIL %s misaligned_err: got %b expected %b", e.name, misaligned_err, e.exp_err);
                end
                $display("txn %-12s pc_out=%h pc_plus4=%h err=%b", e.name, pc_out, pc_plus4, misaligned_err);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        pc_write = 1'b0;
        next_pc  = '0;

        step("reset",     1, 1, 32'h40,       32'h0,        32'h4,  0);
        step("seq4",      0, 1, 32'h4,        32'h4,        32'h8,  0);
        step("seq8",      0, 1, 32'h8,        32'h8,        32'hC,  0);
        step("seq12",     0, 1, 32'hC,        32'hC,        32'h10, 0);
        step("seq16",     0, 1, 32'h10,       32'h10,       32'h14, 0);
        step("seq20",     0, 1, 32'h14,       32'h14,       32'h18, 0);
        step("load8",     0, 1, 32'h8,        32'h8,        32'hC,  0);
        for (int i = 0; i < 3; i++)
            step("stall",  0, 0, 32'h100,     32'h8,        32'hC,  0);
        step("unstall",   0, 1, 32'h100,      32'h100,      32'h104, 0);
        step("load20",    0, 1, 32'h20,       32'h20,       32'h24, 0);
        step("rst_mid",   1, 1, 32'h30,       32'h0,        32'h4,  0);
        step("wrap",      0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,  0);
        step("wrap0",     0, 1, 32'h0,        32'h0,        32'h4,  0);
        step("load10",    0, 1, 32'h10,       32'h10,       32'h14, 0);
        step("mis13",     0, 1, 32'h13,       32'h10,       32'h14, CHK);
        step("mis_end",   0, 0, 32'h13,       32'h10,       32'h14, 0);
        step("mis17",     0, 1, 32'h17,       CHK ? 32'h10 : 32'h14, CHK ? 32'h14 : 32'h18, CHK);
        step("align24",   0, 1, 32'h24,       32'h24,       32'h28, 0);
        step("mis02",     0, 1, 32'h2,        CHK ? 32'h24 : 32'h0,  CHK ? 32'h28 : 32'h4,  CHK);
        step("rst_err",   1, 0, 32'h0,        32'h0,        32'h4,  0);
        step("mis31",     0, 1, 32'h31,       CHK ? 32'h0 : 32'h30,  CHK ? 32'h4 : 32'h34,  CHK);
        step("align30",   0, 1, 32'h30,       32'h30,       32'h34, 0);
        step("hold",      0, 0, 32'h0,        32'h30,       32'h34, 0);

        // Let the monitor drain, bounded so a stuck queue still ends the run.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
